// File: rtl/sram2p_clr.sv
// Simple-dual-port SRAM with byte-enable writes, read-first read port and a zero-fill clear engine.
// Define SRAM2P_OUT_REG_EN to add an output register stage (read latency 2 instead of 1).
module sram2p_clr #(
    parameter  int unsigned DEPTH      = 256,
    parameter  int unsigned ADDR_WIDTH = 8,
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned BYTE_WIDTH = 8,
    localparam int unsigned NBE        = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_req,
    output logic                  init_busy,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [NBE-1:0]        wr_be,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    busy_q, busy_d;
    logic                    rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                    rd_acc_c;
    logic                    wr_acc_c;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // Clear sequencing, access acceptance and read-first data selection
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_data_d  = '0;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = READY;
                    cnt_d   = '0;
                end
            end
            READY: begin
                if (clr_req) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end
            end
            default: state_d = INIT;
        endcase
        busy_d     = (state_d == INIT);
        rd_acc_c   = (state_q == READY) && rd_en;
        wr_acc_c   = (state_q == READY) && wr_en && ({1'b0, wr_addr} < DEPTH_W);
        rd_valid_d = rd_acc_c;
        if (rd_acc_c && ({1'b0, rd_addr} < DEPTH_W)) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Array is never touched on a reset edge; the clear engine zeroes it afterwards
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == INIT) begin
                mem[cnt_q] <= '0;
            end else if (wr_acc_c) begin
                for (int i = 0; i < int'(NBE); i++) begin
                    if (wr_be[i]) begin
                        mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                    end
                end
            end
        end
    end

    assign init_busy = busy_q;

`ifdef SRAM2P_OUT_REG_EN
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;

    // Extra stage is only squashed by reset so reads in flight survive a clr_req
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= rd_valid_q;
            out_data_q  <= rd_data_q;
        end
    end

    assign rd_valid = out_valid_q;
    assign rd_data  = out_data_q;
`else
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
`endif

endmodule

// File: tb/tb_sram2p_clr.sv
// Randomized self-checking bench for sram2p_clr against a countdown/array reference model.
module tb_sram2p_clr;

    localparam int unsigned DEPTH = 12;
    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned BW    = 8;
    localparam int unsigned NBE   = DW / BW;
`ifdef SRAM2P_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst, clr_req, init_busy;
    logic          wr_en, rd_en, rd_valid;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [NBE-1:0] wr_be;
    logic [DW-1:0] wr_data, rd_data;

    sram2p_clr #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW)) dut (
        .clk(clk), .rst(rst), .clr_req(clr_req), .init_busy(init_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit armed  = 1'b0;
    logic [DW-1:0] rd_log[$];

    function automatic void chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Reference model: a countdown of remaining clear writes plus a plain array
    logic [DW-1:0] m_mem [DEPTH];
    int            m_left = 0;
    bit            m_busy = 1'b1;
    logic          s1_v = 1'b0, e_v = 1'b0;
    logic [DW-1:0] s1_d = '0, e_d = '0;

    always @(posedge clk) begin : model
        logic          nv;
        logic [DW-1:0] nd;
        nv = 1'b0;
        nd = '0;
        if (rst) begin
            m_busy = 1'b1;
            m_left = DEPTH;
            s1_v = 1'b0; s1_d = '0;
            e_v  = 1'b0; e_d  = '0;
        end else begin
            if (m_busy) begin
                m_mem[DEPTH - m_left] = '0;
                m_left--;
                if (m_left == 0) m_busy = 1'b0;
            end else begin
                if (rd_en) begin
                    nv = 1'b1;
                    nd = (int'(rd_addr) < DEPTH) ? m_mem[rd_addr] : '0;
                end
                if (wr_en && int'(wr_addr) < DEPTH) begin
                    for (int i = 0; i < int'(NBE); i++)
                        if (wr_be[i]) m_mem[wr_addr][i*BW +: BW] = wr_data[i*BW +: BW];
                end
                if (clr_req) begin
                    m_busy = 1'b1;
                    m_left = DEPTH;
                end
            end
`ifdef SRAM2P_OUT_REG_EN
            e_v = s1_v; e_d = s1_d;
            s1_v = nv;  s1_d = nd;
`else
            e_v = nv; e_d = nd;
`endif
        end
    end

    always @(negedge clk) begin : compare
        if (armed) begin
            chk("init_busy", DW'(init_busy), DW'(m_busy));
            chk("rd_valid", DW'(rd_valid), DW'(e_v));
            chk("rd_data", rd_data, e_d);
            if (rd_valid) rd_log.push_back(rd_data);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NBE-1:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        rd_en = 1'b1; rd_addr = a;
        cyc();
        rd_en = 1'b0;
    endtask

    task automatic drain();
        repeat (3) cyc();
    endtask

    task automatic expect_log(input string nm, input logic [DW-1:0] e);
        logic [DW-1:0] v;
        v = (rd_log.size() > 0) ? rd_log.pop_front() : 32'hDEAD_BEEF;
        chk(nm, v, e);
    endtask

    // Counts busy cycles after a start edge; optional traffic and a mid-clear clr_req pulse
    task automatic count_busy(output int n, input bit traffic, input int clr_at);
        bit seen_valid;
        n = 0;
        seen_valid = 1'b0;
        for (int k = 0; k < 4 * int'(DEPTH); k++) begin
            @(negedge clk);
            clr_req = (k == clr_at);
            if (rd_valid) seen_valid = 1'b1;
            if (!init_busy) break;
            n++;
            if (traffic) begin
                wr_en = 1'b1; wr_addr = AW'(k % 4); wr_data = '1; wr_be = '1;
                rd_en = 1'b1; rd_addr = AW'(k % 4);
            end
        end
        wr_en = 1'b0; rd_en = 1'b0; clr_req = 1'b0;
        if (traffic) chk("init_rd_valid", DW'(seen_valid), '0);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic fill();
        for (int a = 0; a < int'(DEPTH); a++) wr(AW'(a), $urandom, '1);
    endtask

    task automatic read_all_zero(input string nm);
        rd_log.delete();
        for (int a = 0; a < int'(DEPTH); a++) rd(AW'(a));
        drain();
        chk({nm, "_count"}, DW'(rd_log.size()), DW'(DEPTH));
        for (int a = 0; a < int'(DEPTH); a++) expect_log(nm, '0);
    endtask

    initial begin
        int n;
        rst = 1'b1; clr_req = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_be = '0; wr_data = '0;
        cyc();
        armed = 1'b1;
        chk("reset_rd_valid", DW'(rd_valid), '0);
        chk("reset_rd_data", rd_data, '0);
        chk("reset_busy", DW'(init_busy), 32'd1);
        rst = 1'b0;
        count_busy(n, 1'b1, -1);
        chk("busy_len_por", DW'(n), DW'(DEPTH));
        rd_log.delete();
        for (int a = 0; a < 4; a++) rd(AW'(a));
        drain();
        for (int a = 0; a < 4; a++) expect_log("init_write_dropped", '0);

        fill();
        pulse_rst();
        count_busy(n, 1'b0, -1);
        chk("busy_len_rst", DW'(n), DW'(DEPTH));
        read_all_zero("clear_after_rst");

        rd_log.delete();
        wr(5, 32'hAABBCCDD, 4'b1111);
        wr(5, 32'h11223344, 4'b0101);
        rd(5);
        wr(5, 32'h55667788, 4'b0000);
        rd(5);
        drain();
        expect_log("byte_enable", 32'hAA22CC44);
        expect_log("be_zero_noop", 32'hAA22CC44);

        wr(3, 32'h12345678, '1);
        rd_log.delete();
        wr_en = 1'b1; wr_addr = 3; wr_data = 32'hCAFEF00D; wr_be = '1;
        rd_en = 1'b1; rd_addr = 3;
        cyc();
        wr_en = 1'b0;
        cyc();
        rd_en = 1'b0;
        drain();
        expect_log("rdw_old", 32'h12345678);
        expect_log("rdw_new", 32'hCAFEF00D);

        rd_log.delete();
        wr(13, 32'hFFFF_FFFF, '1);
        wr(1, 32'h0000_0001, '1);
        rd(13);
        rd(1);
        drain();
        expect_log("oor_read", '0);
        expect_log("after_oor_write", 32'h0000_0001);

        rd_en = 1'b1; rd_addr = 1;
        @(posedge clk); #2;
        rd_en = 1'b0;
        n = 1;
        @(negedge clk);
        while (!rd_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("read_latency", DW'(n), DW'(LAT));
        drain();

        fill();
        clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        count_busy(n, 1'b0, -1);
        chk("busy_len_clr", DW'(n), DW'(DEPTH));
        read_all_zero("clear_after_clr");

        clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        count_busy(n, 1'b0, 5);
        chk("busy_len_clr_twice", DW'(n), DW'(DEPTH));

        fill();
        clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        repeat (7) cyc();
        pulse_rst();
        count_busy(n, 1'b0, -1);
        chk("busy_len_rst_mid", DW'(n), DW'(DEPTH));
        read_all_zero("clear_after_rst_mid");

        for (int i = 0; i < 3000; i++) begin
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = AW'($urandom_range(0, 15));
            wr_be   = NBE'($urandom);
            wr_data = $urandom;
            rd_en   = 1'($urandom_range(0, 1));
            rd_addr = (i % 2 == 0) ? wr_addr : AW'($urandom_range(0, 15));
            clr_req = ($urandom_range(0, 149) == 0);
            rst     = ($urandom_range(0, 399) == 0);
            cyc();
            if (i % 256 == 0) rd_log.delete();
        end
        rst = 1'b0; clr_req = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
